// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame controller on the UART receive path.
// It finds the start bit, runs the oversampling edge and bit counters
// that steer the sampling stage, deserializes the voted bits, and
// reports each frame as a good word (data_valid) or as a parity and/or
// stop-bit error.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  data_samp_en,
  output logic [5:0]            edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_flag;
  logic                  bit_end;
  logic                  frame_end;
  logic                  start_entry;

  // The last oversampling edge of a bit is the only point where the
  // voted bit is stable, so every decision is taken there.
  assign bit_end     = (state != IDLE) && (edge_cnt == (Prescale - 6'd1));
  assign frame_end   = (state == STOP) && bit_end;
  assign start_entry = (next_state == START) && (state != START);

  // Next-state decode; the sampler is enabled whenever a frame is in progress.
  always_comb begin
    next_state   = state;
    data_samp_en = (state != IDLE);
    case (state)
      IDLE: begin
        if (!RX_IN) next_state = START;
      end
      START: begin
        if (bit_end) next_state = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == LAST_BIT)) next_state = PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) next_state = STOP;
      end
      STOP: begin
        if (bit_end) next_state = RX_IN ? IDLE : START;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Oversampling edge counter: parked at 0 in IDLE, wraps at each bit end
  // so a back-to-back START also begins at edge 0.
  always_ff @(posedge clk) begin
    if (!reset || (state == IDLE) || bit_end) edge_cnt <= 6'd0;
    else                                      edge_cnt <= edge_cnt + 6'd1;
  end

  // Deserializer, data bit counter and parity mismatch flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_flag  <= 1'b0;
    end else if (start_entry) begin
      bit_cnt  <= '0;
      par_flag <= 1'b0;
    end else if ((state == DATA) && bit_end) begin
      shift_reg[bit_cnt] <= sampled_bit;
      if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + CW'(1);
    end else if ((state == PARITY) && bit_end) begin
      par_flag <= sampled_bit ^ (^shift_reg) ^ PAR_TYP;
    end
  end

  // Frame-end reporting: one-cycle pulses, and the word is only published
  // when the frame was clean.
  always_ff @(posedge clk) begin
    if (!reset) begin
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (frame_end) begin
        if (sampled_bit && !par_flag) begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end
        stp_err <= ~sampled_bit;
        par_err <= par_flag;
      end
    end
  end

endmodule
